// File: rtl/mdu_ctrl.sv
// Multiply/divide controller owning the HI/LO registers: holds busy for a fixed
// latency per operation class, then commits the result to HI/LO on a single edge.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  state_e      state, state_d;
  logic [3:0]  cnt, cnt_d;
  logic [1:0]  op_q, op_d;     // op_q[1] = divide class, op_q[0] = unsigned
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] hi_d, lo_d;

  // Result datapath works only on the latched operands, so the inputs are free
  // to change for the whole run.
  logic [63:0] smul, umul;
  logic [31:0] b_safe, abs_a, abs_b, uq, ur, sq, sr, quo, rem;

  always_comb begin
    smul   = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    umul   = {32'd0, a_q} * {32'd0, b_q};
    // Divisor of zero never commits; substitute 1 so the divider stays defined.
    b_safe = (b_q == 32'd0) ? 32'd1 : b_q;
    abs_a  = (!op_q[0] && a_q[31])    ? -a_q    : a_q;
    abs_b  = (!op_q[0] && b_safe[31]) ? -b_safe : b_safe;
    uq     = abs_a / abs_b;
    ur     = abs_a % abs_b;
    // Magnitude division makes 0x80000000 / -1 wrap to 0x80000000 with rem 0.
    sq     = (a_q[31] ^ b_safe[31]) ? -uq : uq;
    sr     = a_q[31] ? -ur : ur;
    quo    = op_q[0] ? uq : sq;
    rem    = op_q[0] ? ur : sr;
  end

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = HI;
    lo_d    = LO;
    unique case (state)
      IDLE: begin
        if (start) begin
          case (md_op_e'(MDOp))
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              op_d    = MDOp[1:0];
              a_d     = SrcA;
              b_d     = SrcB;
              cnt_d   = MDOp[1] ? DIV_LOAD : MULT_LOAD;
              state_d = RUN;
            end
            OP_MTHI: hi_d = SrcA;
            OP_MTLO: lo_d = SrcA;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cnt != 4'd0) begin
          cnt_d = cnt - 4'd1;
        end else begin
          state_d = IDLE;
          if (!op_q[1]) begin
            {hi_d, lo_d} = op_q[0] ? umul : smul;
          end else if (b_q != 32'd0) begin
            hi_d = rem;
            lo_d = quo;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= 4'd0;
      op_q <= 2'd0;
      a_q  <= 32'd0;
      b_q  <= 32'd0;
      HI   <= 32'd0;
      LO   <= 32'd0;
    end else begin
      cnt  <= cnt_d;
      op_q <= op_d;
      a_q  <= a_d;
      b_q  <= b_d;
      HI   <= hi_d;
      LO   <= lo_d;
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: latency, HI/LO commit values, ignored requests
// during RUN, divide-by-zero hold and asynchronous reset mid-operation.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  MDOp;
  logic [31:0] SrcA, SrcB;
  logic        busy;
  logic [31:0] HI, LO;

  int checks   = 0;
  int failures = 0;

  mdu_ctrl dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .MDOp (MDOp),
    .SrcA (SrcA),
    .SrcB (SrcB),
    .busy (busy),
    .HI   (HI),
    .LO   (LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one MULT/DIV-class op and follow it edge by edge. Optionally present an
  // MTLO request on the edge after cycle pulse_at, which must be ignored.
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b, input int n,
                        input logic [31:0] ohi, input logic [31:0] olo,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input int pulse_at);
    start = 1'b1; MDOp = op; SrcA = a; SrcB = b;
    @(posedge clk); #1;
    start = 1'b0; SrcA = ~a; SrcB = 32'h5; MDOp = 3'd7;
    check({tag, " busy@E0"}, {31'd0, busy}, 32'd1);
    check({tag, " hi@E0"}, HI, ohi);
    for (int k = 1; k <= n; k++) begin
      if (k == pulse_at) begin
        start = 1'b1; MDOp = 3'd5; SrcA = 32'hDEADBEEF;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (k < n) begin
        check($sformatf("%s busy@E%0d", tag, k), {31'd0, busy}, 32'd1);
        if (k == n - 1 || k == pulse_at) begin
          check($sformatf("%s hi@E%0d", tag, k), HI, ohi);
          check($sformatf("%s lo@E%0d", tag, k), LO, olo);
        end
      end else begin
        check({tag, " busy_end"}, {31'd0, busy}, 32'd0);
        check({tag, " hi"}, HI, ehi);
        check({tag, " lo"}, LO, elo);
      end
    end
  endtask

  task automatic move_to(input string tag, input logic [2:0] op, input logic [31:0] val,
                         input logic [31:0] ehi, input logic [31:0] elo);
    start = 1'b1; MDOp = op; SrcA = val;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, " busy"}, {31'd0, busy}, 32'd0);
    check({tag, " hi"}, HI, ehi);
    check({tag, " lo"}, LO, elo);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; MDOp = 3'd0; SrcA = 32'd0; SrcB = 32'd0;
    #12;
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst hi", HI, 32'd0);
    check("rst lo", LO, 32'd0);
    reset = 1'b0;

    run_op("mult", 3'd0, 32'hFFFFFFFF, 32'd2, 5, 32'd0, 32'd0,
           32'hFFFFFFFF, 32'hFFFFFFFE, 0);
    run_op("multu", 3'd1, 32'hFFFFFFFF, 32'd2, 5, 32'hFFFFFFFF, 32'hFFFFFFFE,
           32'h00000001, 32'hFFFFFFFE, 0);
    run_op("div_neg", 3'd2, 32'hFFFFFFF9, 32'd2, 10, 32'h00000001, 32'hFFFFFFFE,
           32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    run_op("div_negb", 3'd2, 32'd7, 32'hFFFFFFFE, 10, 32'hFFFFFFFF, 32'hFFFFFFFD,
           32'h00000001, 32'hFFFFFFFD, 0);
    move_to("mthi", 3'd4, 32'h12345678, 32'h12345678, 32'hFFFFFFFD);
    run_op("divu_zero", 3'd3, 32'd55, 32'd0, 10, 32'h12345678, 32'hFFFFFFFD,
           32'h12345678, 32'hFFFFFFFD, 0);
    run_op("divu_ign", 3'd3, 32'd100, 32'd7, 10, 32'h12345678, 32'hFFFFFFFD,
           32'd2, 32'd14, 3);
    run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 10, 32'd2, 32'd14,
           32'd0, 32'h80000000, 0);
    run_op("mult_neg", 3'd0, 32'hFFFFFFFD, 32'h00010000, 5, 32'd0, 32'h80000000,
           32'hFFFFFFFF, 32'hFFFD0000, 0);
    move_to("mtlo", 3'd5, 32'hA5A5A5A5, 32'hFFFFFFFF, 32'hA5A5A5A5);
    move_to("resv", 3'd6, 32'h00001111, 32'hFFFFFFFF, 32'hA5A5A5A5);

    // Reset partway through a MULT: outputs clear without waiting for an edge.
    start = 1'b1; MDOp = 3'd0; SrcA = 32'd7; SrcB = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst busy", {31'd0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_rst busy", {31'd0, busy}, 32'd0);
    check("async_rst hi", HI, 32'd0);
    check("async_rst lo", LO, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    run_op("mult_post", 3'd0, 32'd3, 32'd4, 5, 32'd0, 32'd0, 32'd0, 32'd12, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
